// File: rtl/enemy_hp_ctrl_if.sv
// Attacker handshake bundle between the enemy HP controller and the attack gauge.
// master: HP controller (issues the start request, consumes pass/damage).
// slave : attack gauge (answers with pass flag and damage value).
interface enemy_hp_ctrl_if;
  logic       atk_start;
  logic       atk_pass;
  logic [7:0] atk_damage;

  modport master (output atk_start, input atk_pass, input atk_damage);
  modport slave  (input atk_start, output atk_pass, output atk_damage);
endinterface

// File: rtl/enemy_hp_ctrl.sv
// Enemy HP controller: runs the player attack turn handshake, applies captured
// damage to true HP and drains the display HP toward it at a fixed rate.
// Optional feature macro: HIT_FLASH_EN (hit_flash pulse of FLASH_CYCLES after a hit).
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | waiting for turn_req
// S_REQ      | atk_start held until the gauge drops its pass flag
// S_WAIT_HIT | gauge running; capture damage when pass returns to 1
// S_DRAIN    | display HP stepping down toward true HP
// S_DEAD     | HP reached 0; only new_battle or reset leaves
module enemy_hp_ctrl #(
  parameter int HP_MAX     = 100,
  parameter int DRAIN_DIV  = 4,
  parameter int DRAIN_STEP = 1
`ifdef HIT_FLASH_EN
  ,
  parameter int FLASH_CYCLES = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_turn_req,
  input  logic         i_new_battle,
  enemy_hp_ctrl_if.master atk,
  output logic [7:0]   o_hp,
  output logic [7:0]   o_hp_shown,
  output logic [7:0]   o_last_dmg,
  output logic         o_busy,
  output logic         o_turn_done,
  output logic         o_enemy_dead,
  output logic         o_hit_flash
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_HIT, S_DRAIN, S_DEAD} state_t;

  localparam logic [7:0] HP_INIT = 8'(HP_MAX);
  localparam int CNT_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_DIV - 1);

  state_t r_state, w_state_nxt;
  logic [7:0] r_hp, r_hp_shown, r_last_dmg;
  logic [CNT_W-1:0] r_drain_cnt;
  logic r_atk_start, r_busy, r_turn_done, r_enemy_dead;
  logic w_capture, w_settled;
  logic [7:0] w_gap, w_step;

  assign w_settled = (r_hp_shown == r_hp);
  assign w_capture = (r_state == S_WAIT_HIT) && atk.atk_pass && !i_new_battle;
  assign w_gap     = r_hp_shown - r_hp;
  assign w_step    = (w_gap > 8'(DRAIN_STEP)) ? 8'(DRAIN_STEP) : w_gap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; new_battle overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (i_new_battle) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (i_turn_req) w_state_nxt = S_REQ;
        S_REQ:      if (!atk.atk_pass) w_state_nxt = S_WAIT_HIT;
        S_WAIT_HIT: if (atk.atk_pass) w_state_nxt = S_DRAIN;
        S_DRAIN:    if (w_settled) w_state_nxt = (r_hp == 8'd0) ? S_DEAD : S_IDLE;
        S_DEAD:     w_state_nxt = S_DEAD;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs, HP datapath and drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp         <= HP_INIT;
      r_hp_shown   <= HP_INIT;
      r_last_dmg   <= 8'd0;
      r_drain_cnt  <= '0;
      r_atk_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_turn_done  <= 1'b0;
      r_enemy_dead <= 1'b0;
    end else begin
      // outputs follow the next state so they line up with the state change
      r_atk_start <= (w_state_nxt == S_REQ);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DEAD);
      r_turn_done <= (r_state == S_DRAIN) && w_settled && !i_new_battle;
      if (i_new_battle) begin
        r_hp         <= HP_INIT;
        r_hp_shown   <= HP_INIT;
        r_drain_cnt  <= '0;
        r_enemy_dead <= 1'b0;
      end else begin
        if (w_capture) begin
          r_last_dmg  <= atk.atk_damage;
          r_hp        <= (atk.atk_damage >= r_hp) ? 8'd0 : r_hp - atk.atk_damage;
          r_drain_cnt <= '0;
        end else if ((r_state == S_DRAIN) && !w_settled) begin
          if (r_drain_cnt == CNT_LAST) begin
            r_drain_cnt <= '0;
            r_hp_shown  <= r_hp_shown - w_step;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        if (w_state_nxt == S_DEAD) r_enemy_dead <= 1'b1;
      end
    end
  end

`ifdef HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  logic [FW-1:0] r_flash_cnt;
  logic          r_hit_flash;

  // Hit flash: load on a non-zero hit, hold high until the down-counter expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt <= '0;
      r_hit_flash <= 1'b0;
    end else if (i_new_battle) begin
      r_flash_cnt <= '0;
      r_hit_flash <= 1'b0;
    end else if (w_capture && (atk.atk_damage != 8'd0)) begin
      r_flash_cnt <= FW'(FLASH_CYCLES - 1);
      r_hit_flash <= 1'b1;
    end else if (r_flash_cnt != '0) begin
      r_flash_cnt <= r_flash_cnt - 1'b1;
    end else begin
      r_hit_flash <= 1'b0;
    end
  end

  assign o_hit_flash = r_hit_flash;
`else
  assign o_hit_flash = 1'b0;
`endif

  assign atk.atk_start = r_atk_start;
  assign o_hp          = r_hp;
  assign o_hp_shown    = r_hp_shown;
  assign o_last_dmg    = r_last_dmg;
  assign o_busy        = r_busy;
  assign o_turn_done   = r_turn_done;
  assign o_enemy_dead  = r_enemy_dead;

endmodule
